// File: rtl/sha_256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha_256_pkg;

    localparam int BLOCK_W = 512;
    localparam int LEN_W   = 64;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    // S_FILL collects bytes, S_PAD writes the 0x80 marker and length,
    // S_EMIT offers a block downstream, S_LEN_BLK offers the extra length-only block.
    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_PAD     = 2'd1,
        S_EMIT    = 2'd2,
        S_LEN_BLK = 2'd3
    } state_e;

endpackage

// File: rtl/sha_256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit big-endian blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length.
//
// Handshakes: a beat moves when in_valid & in_ready & ena; a block moves when
// block_valid & block_ready & ena. block_data/block_last stay stable while
// block_valid is high and the block has not been taken. Input is stalled
// (in_ready=0) whenever a block is pending, so no byte is lost or repeated.
module sha_256_padder
    import sha_256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic               in_empty,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] block_data,
    output logic               block_valid,
    output logic               block_last,
    input  logic               block_ready,
    output state_e             dbg_state
);

    state_e             state_q, state_d;
    logic [5:0]         pos_q, pos_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               extra_q, extra_d;   // length spills into a second block
    logic               last_q, last_d;     // block in the buffer ends the message
    logic               pend_q, pend_d;     // final byte filled a block; padding still owed
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic [8:0]         wr_lsb;
    logic               beat_fire;
    logic               blk_fire;

    assign dbg_state = state_q;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        len_d       = len_q;
        extra_d     = extra_q;
        last_d      = last_q;
        pend_d      = pend_q;
        buf_d       = buf_q;
        in_ready    = 1'b0;
        block_valid = 1'b0;
        block_last  = 1'b0;
        block_data  = buf_q;
        beat_fire   = 1'b0;
        blk_fire    = 1'b0;
        wr_lsb      = 9'd504 - {pos_q, 3'b000};

        case (state_q)
            S_FILL: begin
                in_ready  = ena & ~rst;
                beat_fire = in_valid & in_ready;
                if (beat_fire) begin
                    if (!(in_last && in_empty)) begin
                        buf_d[wr_lsb +: 8] = in_byte;
                        pos_d = pos_q + 6'd1;
                        len_d = len_q + 64'd8;
                    end
                    if (in_last) begin
                        if (!in_empty && pos_q == 6'd63) begin
                            // Block is full: ship it first, pad in a fresh block.
                            state_d = S_EMIT;
                            last_d  = 1'b0;
                            pend_d  = 1'b1;
                        end else begin
                            state_d = S_PAD;
                        end
                    end else if (pos_q == 6'd63) begin
                        state_d = S_EMIT;
                        last_d  = 1'b0;
                    end
                end
            end

            S_PAD: begin
                if (ena) begin
                    for (int i = 0; i < 64; i++) begin
                        if (i == int'(pos_q)) begin
                            buf_d[BLOCK_W-8-8*i +: 8] = PAD_BYTE;
                        end else if (i > int'(pos_q)) begin
                            buf_d[BLOCK_W-8-8*i +: 8] = 8'h00;
                        end
                    end
                    if (pos_q <= 6'd55) begin
                        buf_d[LEN_W-1:0] = len_q;
                        last_d = 1'b1;
                    end else begin
                        extra_d = 1'b1;
                        last_d  = 1'b0;
                    end
                    state_d = S_EMIT;
                end
            end

            S_EMIT: begin
                block_valid = ~rst;
                block_last  = last_q & ~rst;
                blk_fire    = block_valid & block_ready & ena;
                if (blk_fire) begin
                    pos_d = 6'd0;
                    if (extra_q) begin
                        state_d = S_LEN_BLK;
                    end else if (last_q) begin
                        state_d = S_FILL;
                        len_d   = '0;
                        buf_d   = '0;
                        last_d  = 1'b0;
                    end else if (pend_q) begin
                        state_d = S_PAD;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end

            S_LEN_BLK: begin
                block_valid = ~rst;
                block_last  = ~rst;
                block_data  = {{(BLOCK_W-LEN_W){1'b0}}, len_q};
                blk_fire    = block_valid & block_ready & ena;
                if (blk_fire) begin
                    state_d = S_FILL;
                    pos_d   = 6'd0;
                    len_d   = '0;
                    extra_d = 1'b0;
                    last_d  = 1'b0;
                    pend_d  = 1'b0;
                    buf_d   = '0;
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            pos_q   <= 6'd0;
            len_q   <= '0;
            extra_q <= 1'b0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            extra_q <= extra_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_sha_256_padder.sv
// Testbench for sha_256_padder: directed padding cases plus random messages
// checked against a byte-level SHA-256 padding model.
module tb_sha_256_padder;
    import sha_256_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [511:0] block_data;
    logic         block_valid;
    logic         block_last;
    logic         block_ready;
    state_e       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [512:0] exp_q[$];   // {block_last, block_data}
    logic [7:0]   msg_q[$];
    bit hold     = 1'b0;
    bit rand_ena = 1'b0;

    sha_256_padder dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_empty   (in_empty),
        .in_ready   (in_ready),
        .block_data (block_data),
        .block_valid(block_valid),
        .block_last (block_last),
        .block_ready(block_ready),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [512:0] got, input logic [512:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: standard SHA-256 padding of msg_q, split into blocks.
    task automatic build_exp();
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        int           nblk;
        p    = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            exp_q.push_back({(b == nblk - 1), blk});
        end
    endtask

    // Driver: offer one beat, hold it until accepted (called at a falling edge).
    task automatic send_beat(input logic [7:0] b, input logic last, input logic empty);
        int budget;
        bit acc;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        in_empty = empty;
        budget   = 0;
        acc      = 1'b0;
        while (!acc && budget < 2000) begin
            #4;
            acc = in_ready && ena;
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        chk("beat_accept", acc, 1);
    endtask

    task automatic send_msg(input bit use_empty);
        int n;
        n = msg_q.size();
        if (n == 0 || use_empty) begin
            for (int i = 0; i < n; i++) send_beat(msg_q[i], 1'b0, 1'b0);
            send_beat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < n; i++) send_beat(msg_q[i], (i == n - 1), 1'b0);
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Downstream ready and enable pattern
    initial begin
        ena         = 1'b1;
        block_ready = 1'b0;
        forever begin
            @(negedge clk);
            block_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            ena         = rand_ena ? ($urandom_range(0, 7) != 0) : 1'b1;
        end
    end

    // Scoreboard: every block transfer is matched against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!ena) chk("ready_when_ena0", in_ready, 0);
            if (block_valid && block_ready && ena) begin
                n_tests++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_block: observed %h expected no block", block_data);
                end
                if (exp_q.size() > 0) chk("block", {block_last, block_data}, exp_q.pop_front());
            end
        end
    end

    // Directed and random stimulus
    initial begin
        logic [511:0] held;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        in_last  = 1'b0;
        in_empty = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_block_valid", block_valid, 0);
        chk("rst_block_last", block_last, 0);
        @(negedge clk);
        rst = 1'b0;
        #4;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_block_valid", block_valid, 0);
        chk("post_rst_state", dbg_state, S_FILL);
        @(negedge clk);

        // "abc" with final-block latency check
        hold = 1'b1;
        msg_q = '{8'h61, 8'h62, 8'h63};
        build_exp();
        send_msg(1'b0);
        #4;
        chk("lat_pad_valid", block_valid, 0);
        chk("lat_pad_state", dbg_state, S_PAD);
        @(negedge clk);
        #4;
        chk("lat_emit_valid", block_valid, 1);
        chk("lat_emit_last", block_last, 1);
        @(negedge clk);
        hold = 1'b0;
        wait_drain();

        // zero-length message
        msg_q.delete();
        build_exp();
        send_msg(1'b1);
        wait_drain();

        // 55 bytes: padding and length fit in one block
        msg_q.delete();
        for (int i = 0; i < 55; i++) msg_q.push_back(8'(i));
        build_exp();
        send_msg(1'b0);
        wait_drain();

        // 56 bytes: length spills into a second block
        msg_q.delete();
        for (int i = 0; i < 56; i++) msg_q.push_back(8'(i + 3));
        build_exp();
        send_msg(1'b0);
        wait_drain();

        // 64 bytes with downstream stalled for 5 cycles
        hold = 1'b1;
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom_range(0, 255)));
        build_exp();
        send_msg(1'b0);
        #4;
        chk("full_blk_valid", block_valid, 1);
        chk("full_blk_last", block_last, 0);
        held = block_data;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #4;
            chk("hold_stable", block_data, held);
            chk("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        hold = 1'b0;
        wait_drain();

        // reset after 30 bytes, then "abc"
        for (int i = 0; i < 30; i++) send_beat(8'(i + 1), 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset while a block is pending
        hold = 1'b1;
        for (int i = 0; i < 64; i++) send_beat(8'(i + 100), 1'b0, 1'b0);
        #4;
        chk("emit_pending", block_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        hold = 1'b0;
        repeat (20) @(negedge clk);
        #4;
        chk("no_block_after_rst", block_valid, 0);
        @(negedge clk);

        msg_q = '{8'h61, 8'h62, 8'h63};
        build_exp();
        send_msg(1'b0);
        wait_drain();

        // random messages with random enable and back-pressure
        rand_ena = 1'b1;
        for (int m = 0; m < 8; m++) begin
            int len;
            len = $urandom_range(0, 140);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
            build_exp();
            send_msg(bit'($urandom_range(0, 1)));
            wait_drain();
        end
        rand_ena = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha_256_padder.md
SHA_256_PADDER -- requirements
Module: sha_256_padder

Interface
REQ-001 SHALL have clk input 1: rising-edge clock for all state.
REQ-002 SHALL have rst input 1: reset, synchronous, active-high; clock clk.
REQ-003 SHALL have ena input 1: when 0, no state changes, in_ready=0, and no output handshake completes.
REQ-004 SHALL have in_byte input 8: message byte, first byte of message first.
REQ-005 SHALL have in_valid input 1: in_byte/in_last/in_empty valid.
REQ-006 SHALL have in_last input 1: beat is final beat of message.
REQ-007 SHALL have in_empty input 1: only meaningful with in_last; beat carries no byte (zero-length message).
REQ-008 SHALL have in_ready output 1: padder accepts beat this cycle.
REQ-009 SHALL have block_data output 512: padded block, big-endian, first byte at [511:504].
REQ-010 SHALL have block_valid output 1: block_data holds a complete block.
REQ-011 SHALL have block_last output 1: block is final block of message.
REQ-012 SHALL have block_ready input 1: downstream hash core takes the block.

Function
REQ-013 Beat transfer SHALL occur when in_valid & in_ready & ena; block transfer SHALL occur when block_valid & block_ready & ena.
REQ-014 States SHALL be S_FILL, S_PAD, S_EMIT, S_LEN_BLK.
REQ-015 S_FILL: in_ready=1, block_valid=0; each accepted byte is written at byte position pos (6-bit, 0..63), then pos increments and the 64-bit bit-length counter adds 8.
REQ-016 S_FILL, 64th byte accepted with in_last=0: pos SHALL wrap to 0; next state S_EMIT with block_last=0.
REQ-017 S_FILL, in_last accepted (byte stored unless in_empty=1): next state S_PAD.
REQ-018 S_PAD, one cycle, in_ready=0: write 0x80 at pos and zero all later bytes.
- pos<=55: write the bit length to [63:0]; next S_EMIT with block_last=1.
- pos>=56: set extra-block flag; next S_EMIT with block_last=0.
- pos==0 after a full 64-byte block: emit the 0x80 block with length (pos<=55 case).
REQ-019 S_EMIT: block_valid=1, in_ready=0; block_data, block_valid and block_last SHALL hold stable until transfer.
REQ-020 On S_EMIT transfer, the next state SHALL be:
- extra-block flag set: S_LEN_BLK;
- block_last=1: S_FILL, with pos=0, length counter=0 and block buffer cleared;
- otherwise: S_FILL with pos=0.
REQ-021 S_LEN_BLK: block_valid=1, block_data = 448 zero bits followed by the 64-bit length, block_last=1; on transfer SHALL go to S_FILL with all counters cleared.
REQ-022 First block_valid after the accepting edge of the final beat SHALL appear 2 cycles later (S_PAD then S_EMIT); a full non-final block SHALL appear 1 cycle later.
REQ-023 Length counter SHALL be 64 bits and wrap modulo 2^64.
REQ-024 Simultaneous in_valid and a pending block: the beat SHALL be stalled via in_ready=0; no byte SHALL be lost or duplicated.

Reset
REQ-025 rst SHALL force S_FILL, pos=0, length=0, extra flag=0, buffer=0, in_ready=0 during reset, block_valid=0, block_last=0.
REQ-026 rst mid-message or mid-emit SHALL discard all partial data, with no block emitted afterwards.

Structure
REQ-027 Package sha_256_pkg SHALL hold the state enum type and the constants BLOCK_W=512, LEN_W=64, and PAD_BYTE=8'h80.
REQ-028 Single module with no sub-modules; block_data SHALL drive the existing hash accelerator's input_data directly, with block_valid as its input_valid.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- "abc" (61 62 63, last on 63) -> one block 0x61626380, zeros, [63:0]=0x18, block_last=1.
- Single beat in_last=1, in_empty=1 -> block 0x80 then zeros, length 0, block_last=1.
- 55 bytes 0x00..0x36 -> one block, byte55=0x80, length 0x1B8, last=1.
- 56 bytes -> block 1 = data + 0x80 + zeros with last=0; block 2 = zeros + length 0x1C0 with last=1.
- 64 bytes -> data block (last=0), then 0x80 block with length 0x200 (last=1); hold block_ready=0 for 5 cycles and check block_data stable and in_ready=0.
- rst after 30 bytes, then "abc" -> only the "abc" block appears, with length 0x18.
